phase_sequencer: RTL

Parametrised multi-phase clock sequencer for the SIMPLE processor. Generates NUM_PHASES one-hot phase strobes per instruction, each phase lasting PHASE_CYCLES system clocks. Adds run, single-step and halt control driven by debounced front-panel buttons. Sits between the board clock and the datapath/phase-enabled register stages.

---
 rtl/phase_seq_pkg.sv | 25 ++
 rtl/phase_sequencer_button_debouncer.sv | 54 +++++
 rtl/phase_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/phase_seq_pkg.sv
// -----------------------------------------------------------------------------
// phase_seq_pkg
//   Shared types and width helpers for the SIMPLE processor phase sequencer.
//   - seq_state_t      : sequencer control states (IDLE, RUN, HALTED)
//   - phase_idx_width  : bits needed for a phase number (minimum 1)
//   - cyc_cnt_width    : bits needed for the in-phase cycle counter (minimum 1)
// -----------------------------------------------------------------------------
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    // A counter that only ever holds 0 still needs one physical bit.
    function automatic int phase_idx_width(input int num_phases);
        return (num_phases > 1) ? $clog2(num_phases) : 1;
    endfunction

    function automatic int cyc_cnt_width(input int phase_cycles);
        return (phase_cycles > 1) ? $clog2(phase_cycles) : 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Synchronises a raw front-panel button, accepts a new level only after
//   DEBOUNCE_CYCLES consecutive samples that disagree with the current level,
//   and emits a one-cycle pulse when the accepted level rises.
//   A clean rising edge on btn yields pulse 2+DEBOUNCE_CYCLES clocks later.
//
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset
//   btn      in   raw button level, active-high, asynchronous to clock
//   pulse    out  one-cycle pulse on an accepted rising level
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             level;

    // cnt counts consecutive synchronised samples that differ from level;
    // any agreeing sample restarts the count, so short bounces never land.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking for all state so every flop samples pre-edge values.
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync[1];
                pulse <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Multi-phase clock sequencer for the SIMPLE processor. Each instruction is
//   NUM_PHASES phases of PHASE_CYCLES clocks; the one-hot strobe for a phase is
//   high in the first clock of that phase. Run / single-step / halt control is
//   driven by a debounced exec button, step_mode and the datapath halt_in.
//   A stop (step, exec press or halt) always lets the current instruction
//   finish; halt wins over a plain stop and is left only through reset_n.
//
//   Build option: define PHASE_SEQ_INSTR_COUNT_EN to add instr_count, a
//   wrapping 16-bit count of completed instructions.
//
// Ports:
//   clock         in   system clock
//   reset_n       in   asynchronous active-low reset
//   exec_btn      in   raw exec button, active-high
//   step_mode     in   1 = single-step, 0 = free run (read on IDLE->RUN)
//   halt_in       in   datapath halt request, sampled every cycle
//   phase_strobe  out  one-hot phase strobe (registered)
//   phase_index   out  current phase number (holds in IDLE/HALTED)
//   running       out  sequencer is in RUN
//   halted        out  sequencer is in HALTED
//   instr_count   out  completed instructions (PHASE_SEQ_INSTR_COUNT_EN only)
//   exec_pulse    out  one-cycle debounced exec press
// -----------------------------------------------------------------------------
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES      = 5,
    parameter int PHASE_CYCLES    = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          exec_btn,
    input  logic                          step_mode,
    input  logic                          halt_in,
    output logic [NUM_PHASES-1:0]         phase_strobe,
    output logic [$clog2(NUM_PHASES)-1:0] phase_index,
    output logic                          running,
    output logic                          halted,
`ifdef PHASE_SEQ_INSTR_COUNT_EN
    output logic [15:0]                   instr_count,
`endif
    output logic                          exec_pulse
);

    localparam int PW = phase_idx_width(NUM_PHASES);
    localparam int CW = cyc_cnt_width(PHASE_CYCLES);
    localparam logic [PW-1:0] PH_LAST  = PW'(NUM_PHASES - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(PHASE_CYCLES - 1);

    seq_state_t            state, state_next;
    logic [PW-1:0]         phase, phase_next;
    logic [CW-1:0]         cyc, cyc_next;
    logic                  stop_pending, stop_next;
    logic                  halt_seen, halt_next;
    logic [NUM_PHASES-1:0] strobe_next;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_exec_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (exec_btn),
        .pulse   (exec_pulse)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            phase        <= '0;
            cyc          <= '0;
            stop_pending <= 1'b0;
            halt_seen    <= 1'b0;
            phase_strobe <= '0;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            cyc          <= cyc_next;
            stop_pending <= stop_next;
            halt_seen    <= halt_next;
            phase_strobe <= strobe_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_next  = state;
        phase_next  = phase;
        cyc_next    = cyc;
        stop_next   = stop_pending;
        halt_next   = halt_seen;
        strobe_next = '0;

        unique case (state)
            ST_IDLE: begin
                if (exec_pulse) begin
                    state_next = ST_RUN;
                    phase_next = '0;
                    cyc_next   = '0;
                    stop_next  = step_mode;
                    halt_next  = 1'b0;
                end
            end
            ST_RUN: begin
                // Requests arriving in the final cycle still count for this
                // instruction, so a simultaneous halt and press ends in HALTED.
                halt_next = halt_seen | halt_in;
                stop_next = stop_pending | halt_in | exec_pulse;
                if (cyc != CYC_LAST) begin
                    cyc_next = cyc + CW'(1);
                end else begin
                    cyc_next = '0;
                    if (phase != PH_LAST) begin
                        phase_next = phase + PW'(1);
                    end else if (halt_next) begin
                        state_next = ST_HALTED;
                    end else if (stop_next) begin
                        state_next = ST_IDLE;
                    end else begin
                        phase_next = '0;
                    end
                end
            end
            ST_HALTED: ;
            default: state_next = ST_IDLE;
        endcase

        // Strobe is registered alongside phase, so it lines up with phase_index.
        if (state_next == ST_RUN && cyc_next == '0)
            strobe_next = NUM_PHASES'(1) << phase_next;
    end

    assign phase_index = phase;
    assign running     = (state == ST_RUN);
    assign halted      = (state == ST_HALTED);

`ifdef PHASE_SEQ_INSTR_COUNT_EN
    logic instr_done;
    assign instr_done = (state == ST_RUN) && (cyc == CYC_LAST) && (phase == PH_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            instr_count <= '0;
        else if (instr_done)
            instr_count <= instr_count + 16'd1;
    end
`endif

endmodule
